multicycle_controller: RTL and testbench
========================================

MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

Interface
REQ-001 Parameter INSTRET_W, default 32, sets the width of the retired-instruction counter.
REQ-002 Port clk  input  1  is the single clock; all state changes on its rising edge.
REQ-003 Port rst_n  input  1  is the asynchronous, active-low reset.
REQ-004 Port opcode  input  7  is instruction[6:0] from the instruction register.
REQ-005 Port zero  input  1  is the ALU zero flag.
REQ-006 Port mem_ready  input  1  is the memory completion strobe for the current mem_req.
REQ-007 Port mem_req  output  1  is the memory access request.
REQ-008 Port mem_we  output  1  is the memory write enable: 1 = store.
REQ-009 Port mem_addr_sel  output  1  is the memory address select: 0 = PC, 1 = ALU result.
REQ-010 Port ir_write  output  1  is the instruction register load strobe.
REQ-011 Port pc_write  output  1  is the PC load strobe.
REQ-012 Port pc_src  output  1  is the PC source select: 0 = PC+4, 1 = branch target (PC + immediate).
REQ-013 Port alu_src_b  output  1  is the ALU B select: 0 = rs2, 1 = immediate.
REQ-014 Port alu_op  output  2  is the ALU operation: 00 = add, 01 = subtract, 10 = funct-decoded.
REQ-015 Port reg_write  output  1  is the register file write strobe.
REQ-016 Port mem_to_reg  output  1  is the writeback select: 1 = memory data, 0 = ALU result.
REQ-017 Port illegal  output  1  is a sticky illegal-opcode flag.
REQ-018 Port state  output  3  is the current FSM state encoding.
REQ-019 Port instret  output  INSTRET_W  is the retired-instruction count.

Function
REQ-020 The FSM SHALL use these states and encodings: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, TRAP=5; codes 6 and 7 SHALL go to FETCH on the next clock.
REQ-021 Any strobe or select output not asserted by REQ-022 to REQ-030 in the current state SHALL be 0.
REQ-022 FETCH SHALL assert mem_req=1, mem_we=0 and mem_addr_sel=0, and SHALL hold until mem_ready=1.
REQ-023 In that same FETCH cycle with mem_ready=1, the block SHALL assert ir_write=1 and pc_write=1 with pc_src=0, and SHALL go to DECODE.
REQ-024 DECODE SHALL register opcode into opcode_q; opcode_q alone SHALL steer EXEC, MEM and WB.
REQ-025 From DECODE, opcodes 0000011 (LW), 0100011 (SW), 1100011 (BEQ) and 0110011 (R-type) SHALL go to EXEC; any other opcode SHALL go to TRAP.
REQ-026 In EXEC for LW or SW: alu_src_b=1, alu_op=00, next state MEM.
REQ-027 In EXEC for R-type: alu_src_b=0, alu_op=10, next state WB.
REQ-028 In EXEC for BEQ: alu_src_b=0, alu_op=01, next state FETCH; pc_write=1 and pc_src=1 only if zero=1 in that cycle.
REQ-029 MEM SHALL assert mem_req=1 and mem_addr_sel=1, with mem_we=1 for SW only, and SHALL hold until mem_ready=1; it then goes to FETCH for SW and to WB for LW.
REQ-030 WB SHALL assert reg_write=1 for exactly one cycle, with mem_to_reg=1 for LW and 0 for R-type, then go to FETCH.
REQ-031 Retirement SHALL be counted by incrementing instret by 1 on the clock edge leaving EXEC (BEQ), MEM (SW) or WB (LW, R-type).
REQ-032 instret SHALL wrap from all-ones to 0 with no flag.
REQ-033 mem_ready SHALL be ignored in DECODE, EXEC, WB and TRAP.
REQ-034 mem_req SHALL stay asserted and stable while waiting, for any number of cycles.
REQ-035 TRAP SHALL set illegal=1 and hold all strobes at 0; the block SHALL leave TRAP only by reset.
REQ-036 Instruction latency in cycles, with zero memory wait states, SHALL be: BEQ 3, R-type 4, SW 4, LW 5; each memory wait cycle SHALL add 1.

Reset
REQ-037 rst_n=0 SHALL force, asynchronously and regardless of state (including mid-MEM with mem_req high): state=FETCH, opcode_q=0, instret=0, illegal=0, and all strobes 0.
REQ-038 While rst_n=0, mem_req SHALL be 0 even though the state is FETCH.
REQ-039 After rst_n rises, the first clock edge SHALL be evaluated as FETCH, with mem_req=1 in the cycle after release.

Verification
REQ-040 LW, mem_ready tied 1 -> states 0,1,2,3,4,0; reg_write=1 with mem_to_reg=1 in cycle 5 only; instret 0 -> 1.
REQ-041 SW with mem_ready held 0 for 3 MEM cycles -> mem_req=1, mem_we=1, mem_addr_sel=1 stable for 4 cycles; reg_write never 1; instret +1.
REQ-042 BEQ with zero=1 -> pc_write=1 and pc_src=1 in EXEC; BEQ with zero=0 -> pc_write=0 in EXEC; each takes 3 cycles.
REQ-043 opcode 1111111 -> TRAP, illegal=1, no mem_req for 20 cycles; then rst_n pulse -> illegal=0, state=0.
REQ-044 rst_n asserted mid-MEM of LW -> mem_req=0 and state=0 without a clock edge; instret unchanged at 0.
REQ-045 Preload instret=all-ones (INSTRET_W=4: 15) and retire one R-type -> instret=0.

Source files
------------

// File: rtl/multicycle_controller.sv
// ----------------------------------------------------------------------------
// multicycle_controller
//
// Control FSM for a multicycle RISC-V style datapath handling LW, SW, BEQ and
// R-type instructions. Each instruction walks FETCH -> DECODE -> EXEC
// [-> MEM] [-> WB]. Any unsupported opcode parks the FSM in TRAP until reset.
//
// Parameters
//   INSTRET_W     width of the retired-instruction counter
//
// Ports
//   clk           clock, all state changes on the rising edge
//   rst_n         asynchronous active-low reset
//   opcode[6:0]   instruction[6:0] from the instruction register
//   zero          ALU zero flag (used by BEQ in EXEC)
//   mem_ready     completion strobe for the current mem_req
//   mem_req       memory access request
//   mem_we        memory write enable (1 = store)
//   mem_addr_sel  memory address select (0 = PC, 1 = ALU result)
//   ir_write      instruction register load strobe
//   pc_write      PC load strobe
//   pc_src        PC source (0 = PC+4, 1 = branch target)
//   alu_src_b     ALU B select (0 = rs2, 1 = immediate)
//   alu_op[1:0]   ALU operation (00 add, 01 subtract, 10 funct-decoded)
//   reg_write     register file write strobe
//   mem_to_reg    writeback select (1 = memory data, 0 = ALU result)
//   illegal       sticky illegal-opcode flag
//   state[2:0]    current FSM state encoding
//   instret       retired-instruction count (wraps silently)
// ----------------------------------------------------------------------------
module multicycle_controller #(
    parameter int INSTRET_W = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [6:0]           opcode,
    input  logic                 zero,
    input  logic                 mem_ready,
    output logic                 mem_req,
    output logic                 mem_we,
    output logic                 mem_addr_sel,
    output logic                 ir_write,
    output logic                 pc_write,
    output logic                 pc_src,
    output logic                 alu_src_b,
    output logic [1:0]           alu_op,
    output logic                 reg_write,
    output logic                 mem_to_reg,
    output logic                 illegal,
    output logic [2:0]           state,
    output logic [INSTRET_W-1:0] instret
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_TRAP   = 3'd5
    } state_t;

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;
    localparam logic [6:0] OP_R   = 7'b0110011;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;

    state_t                 state_reg;
    state_t                 state_next;
    logic [6:0]             opcode_q;
    logic                   illegal_reg;
    logic [INSTRET_W-1:0]   instret_reg;
    logic                   retire;

    // Raw (ungated) control outputs produced by the next-state logic.
    logic                   mem_req_raw;
    logic                   mem_we_raw;
    logic                   mem_addr_sel_raw;
    logic                   ir_write_raw;
    logic                   pc_write_raw;
    logic                   pc_src_raw;
    logic                   alu_src_b_raw;
    logic [1:0]             alu_op_raw;
    logic                   reg_write_raw;
    logic                   mem_to_reg_raw;

    // Instruction class of the latched opcode; only opcode_q steers the
    // later states so the IR may change underneath without effect.
    logic is_lw;
    logic is_sw;
    logic is_beq;
    logic is_r;

    assign is_lw  = (opcode_q == OP_LW);
    assign is_sw  = (opcode_q == OP_SW);
    assign is_beq = (opcode_q == OP_BEQ);
    assign is_r   = (opcode_q == OP_R);

    function automatic logic op_supported(input logic [6:0] op);
        return (op == OP_LW) || (op == OP_SW) || (op == OP_BEQ) || (op == OP_R);
    endfunction

    // ------------------------------------------------------------------
    // State and bookkeeping registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= S_FETCH;
            opcode_q    <= 7'd0;
            illegal_reg <= 1'b0;
            instret_reg <= '0;
        end else begin
            state_reg <= state_next;
            if (state_reg == S_DECODE) begin
                opcode_q <= opcode;
            end
            // Set on the edge entering TRAP so the flag is visible for the
            // whole time the FSM sits there.
            if (state_next == S_TRAP) begin
                illegal_reg <= 1'b1;
            end
            if (retire) begin
                instret_reg <= instret_reg + INSTRET_W'(1);
            end
        end
    end

    // ------------------------------------------------------------------
    // Next-state and control decode
    // ------------------------------------------------------------------
    always_comb begin
        state_next       = state_reg;
        retire           = 1'b0;
        mem_req_raw      = 1'b0;
        mem_we_raw       = 1'b0;
        mem_addr_sel_raw = 1'b0;
        ir_write_raw     = 1'b0;
        pc_write_raw     = 1'b0;
        pc_src_raw       = 1'b0;
        alu_src_b_raw    = 1'b0;
        alu_op_raw       = ALU_ADD;
        reg_write_raw    = 1'b0;
        mem_to_reg_raw   = 1'b0;

        case (state_reg)
            S_FETCH: begin
                // Request is held constant for as long as memory stalls.
                mem_req_raw = 1'b1;
                if (mem_ready) begin
                    ir_write_raw = 1'b1;
                    pc_write_raw = 1'b1;
                    state_next   = S_DECODE;
                end
            end

            S_DECODE: begin
                state_next = op_supported(opcode) ? S_EXEC : S_TRAP;
            end

            S_EXEC: begin
                if (is_lw || is_sw) begin
                    alu_src_b_raw = 1'b1;
                    alu_op_raw    = ALU_ADD;
                    state_next    = S_MEM;
                end else if (is_r) begin
                    alu_op_raw = ALU_FUNCT;
                    state_next = S_WB;
                end else if (is_beq) begin
                    alu_op_raw = ALU_SUB;
                    // Branch taken: PC <- PC + imm in this same cycle.
                    if (zero) begin
                        pc_write_raw = 1'b1;
                        pc_src_raw   = 1'b1;
                    end
                    retire     = 1'b1;
                    state_next = S_FETCH;
                end else begin
                    // opcode_q is always a supported opcode here; keep the
                    // FSM safe should it ever be corrupted.
                    state_next = S_TRAP;
                end
            end

            S_MEM: begin
                mem_req_raw      = 1'b1;
                mem_addr_sel_raw = 1'b1;
                mem_we_raw       = is_sw;
                if (mem_ready) begin
                    if (is_sw) begin
                        retire     = 1'b1;
                        state_next = S_FETCH;
                    end else begin
                        state_next = S_WB;
                    end
                end
            end

            S_WB: begin
                reg_write_raw  = 1'b1;
                mem_to_reg_raw = is_lw;
                retire         = 1'b1;
                state_next     = S_FETCH;
            end

            S_TRAP: begin
                state_next = S_TRAP;
            end

            default: begin
                // Unused encodings 6 and 7 recover to FETCH.
                state_next = S_FETCH;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Outputs. The state register already reads FETCH during reset, but
    // FETCH would normally drive mem_req, so every strobe is additionally
    // masked by rst_n to keep the bus quiet while reset is held.
    // ------------------------------------------------------------------
    assign mem_req      = rst_n & mem_req_raw;
    assign mem_we       = rst_n & mem_we_raw;
    assign mem_addr_sel = rst_n & mem_addr_sel_raw;
    assign ir_write     = rst_n & ir_write_raw;
    assign pc_write     = rst_n & pc_write_raw;
    assign pc_src       = rst_n & pc_src_raw;
    assign alu_src_b    = rst_n & alu_src_b_raw;
    assign alu_op       = alu_op_raw & {2{rst_n}};
    assign reg_write    = rst_n & reg_write_raw;
    assign mem_to_reg   = rst_n & mem_to_reg_raw;

    assign illegal = illegal_reg;
    assign state   = state_reg;
    assign instret = instret_reg;

endmodule

// File: tb/tb_multicycle_controller.sv
// ----------------------------------------------------------------------------
// tb_multicycle_controller
//
// Randomized self-checking bench. For each instruction a reference model
// expands the instruction class, memory wait counts and zero flag into a
// per-cycle script of inputs and expected outputs; the script is then
// replayed against the DUT one cycle at a time. instret is tracked with a
// plain modulo-16 counter (INSTRET_W = 4 so wrap is exercised).
// ----------------------------------------------------------------------------
module tb_multicycle_controller;

    localparam int IW = 4;

    localparam int K_LW  = 0;
    localparam int K_SW  = 1;
    localparam int K_BEQ = 2;
    localparam int K_R   = 3;
    localparam int K_ILL = 4;

    logic          clk;
    logic          rst_n;
    logic [6:0]    opcode;
    logic          zero;
    logic          mem_ready;
    logic          mem_req;
    logic          mem_we;
    logic          mem_addr_sel;
    logic          ir_write;
    logic          pc_write;
    logic          pc_src;
    logic          alu_src_b;
    logic [1:0]    alu_op;
    logic          reg_write;
    logic          mem_to_reg;
    logic          illegal;
    logic [2:0]    state;
    logic [IW-1:0] instret;

    multicycle_controller #(.INSTRET_W(IW)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .opcode       (opcode),
        .zero         (zero),
        .mem_ready    (mem_ready),
        .mem_req      (mem_req),
        .mem_we       (mem_we),
        .mem_addr_sel (mem_addr_sel),
        .ir_write     (ir_write),
        .pc_write     (pc_write),
        .pc_src       (pc_src),
        .alu_src_b    (alu_src_b),
        .alu_op       (alu_op),
        .reg_write    (reg_write),
        .mem_to_reg   (mem_to_reg),
        .illegal      (illegal),
        .state        (state),
        .instret      (instret)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Observed vector: {state, mem_req, mem_we, mem_addr_sel, ir_write,
    //                   pc_write, pc_src, alu_src_b, alu_op, reg_write,
    //                   mem_to_reg, illegal}
    logic [14:0] obs;
    assign obs = {state, mem_req, mem_we, mem_addr_sel, ir_write, pc_write,
                  pc_src, alu_src_b, alu_op, reg_write, mem_to_reg, illegal};

    typedef struct packed {
        logic [6:0]  op;
        logic        rdy;
        logic        z;
        logic [14:0] exp;
    } step_t;

    step_t       script[$];
    int          checks = 0;
    int          errors = 0;
    logic [IW-1:0] exp_cnt;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // s7 = {mem_req, mem_we, mem_addr_sel, ir_write, pc_write, pc_src, alu_src_b}
    // tl = {reg_write, mem_to_reg, illegal}
    function automatic logic [14:0] vec(input logic [2:0] st, input logic [6:0] s7,
                                        input logic [1:0] aop, input logic [2:0] tl);
        return {st, s7, aop, tl};
    endfunction

    function automatic logic [6:0] rnd_op();
        return 7'($urandom_range(0, 127));
    endfunction

    function automatic logic rnd_bit();
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic logic [6:0] kind_op(input int kind);
        logic [6:0] op;
        case (kind)
            K_LW:    op = 7'b0000011;
            K_SW:    op = 7'b0100011;
            K_BEQ:   op = 7'b1100011;
            K_R:     op = 7'b0110011;
            default: begin
                do op = rnd_op();
                while (op == 7'b0000011 || op == 7'b0100011 ||
                       op == 7'b1100011 || op == 7'b0110011);
            end
        endcase
        return op;
    endfunction

    task automatic add(input logic [6:0] op, input logic rdy, input logic z, input logic [14:0] e);
        step_t s;
        s.op = op; s.rdy = rdy; s.z = z; s.exp = e;
        script.push_back(s);
    endtask

    // Expand one instruction into its expected cycle sequence.
    task automatic plan(input int kind, input int fw, input int mw, input logic z,
                        input int trap_len);
        logic [6:0] op;
        logic       sw;
        op = kind_op(kind);
        sw = (kind == K_SW);
        for (int i = 0; i < fw; i++)
            add(rnd_op(), 1'b0, rnd_bit(), vec(3'd0, 7'b1000000, 2'b00, 3'b000));
        add(rnd_op(), 1'b1, rnd_bit(), vec(3'd0, 7'b1001100, 2'b00, 3'b000));
        add(op, rnd_bit(), rnd_bit(), vec(3'd1, 7'b0000000, 2'b00, 3'b000));
        if (kind == K_ILL) begin
            for (int i = 0; i < trap_len; i++)
                add(rnd_op(), rnd_bit(), rnd_bit(), vec(3'd5, 7'b0000000, 2'b00, 3'b001));
            return;
        end
        case (kind)
            K_LW, K_SW: add(rnd_op(), rnd_bit(), rnd_bit(), vec(3'd2, 7'b0000001, 2'b00, 3'b000));
            K_R:        add(rnd_op(), rnd_bit(), rnd_bit(), vec(3'd2, 7'b0000000, 2'b10, 3'b000));
            default:    add(rnd_op(), rnd_bit(), z, vec(3'd2, {4'b0000, z, z, 1'b0}, 2'b01, 3'b000));
        endcase
        if (kind == K_LW || kind == K_SW) begin
            for (int i = 0; i <= mw; i++)
                add(rnd_op(), (i == mw), rnd_bit(),
                    vec(3'd3, {1'b1, sw, 1'b1, 4'b0000}, 2'b00, 3'b000));
        end
        if (kind == K_LW)
            add(rnd_op(), rnd_bit(), rnd_bit(), vec(3'd4, 7'b0000000, 2'b00, 3'b110));
        if (kind == K_R)
            add(rnd_op(), rnd_bit(), rnd_bit(), vec(3'd4, 7'b0000000, 2'b00, 3'b100));
    endtask

    // Called just after a falling edge; returns just after the next one.
    task automatic run_step(input string tag);
        step_t s;
        s = script.pop_front();
        opcode = s.op; mem_ready = s.rdy; zero = s.z;
        #1;
        check(tag, 32'(obs), 32'(s.exp));
        @(negedge clk);
    endtask

    task automatic run_instr(input int kind, input int fw, input int mw, input logic z,
                             input int trap_len);
        plan(kind, fw, mw, z, trap_len);
        $display("instr kind=%0d fw=%0d mw=%0d z=%0d cycles=%0d", kind, fw, mw, z, script.size());
        while (script.size() > 0) run_step("cycle");
        if (kind != K_ILL) exp_cnt = exp_cnt + 1'b1;
        check("instret", 32'(instret), 32'(exp_cnt));
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        opcode = rnd_op(); mem_ready = 1'b1; zero = 1'b1;
        #1;
        check("rst_vec", 32'(obs), 32'(vec(3'd0, 7'b0000000, 2'b00, 3'b000)));
        check("rst_instret", 32'(instret), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        exp_cnt = '0;
        $display("reset released");
    endtask

    task automatic run_random(input int n, input bit allow_ill);
        int kind;
        for (int i = 0; i < n; i++) begin
            kind = (allow_ill && $urandom_range(0, 99) < 3) ? K_ILL : int'($urandom_range(0, 3));
            run_instr(kind,
                      ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(1, 3)),
                      ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(1, 4)),
                      rnd_bit(), 6);
            if (kind == K_ILL) do_reset();
        end
    endtask

    initial begin
        rst_n = 1'b0; opcode = '0; zero = 1'b0; mem_ready = 1'b0;
        exp_cnt = '0;
        @(negedge clk);
        do_reset();

        // Directed: LW no waits, SW with 3 MEM waits, BEQ taken / not taken, R-type.
        run_instr(K_LW,  0, 0, 1'b0, 0);
        run_instr(K_SW,  0, 3, 1'b0, 0);
        run_instr(K_BEQ, 0, 0, 1'b1, 0);
        run_instr(K_BEQ, 0, 0, 1'b0, 0);
        run_instr(K_R,   0, 0, 1'b0, 0);
        run_instr(K_LW,  2, 1, 1'b0, 0);

        // Counter wrap: fifteen retirements to reach all-ones, then one R-type.
        do_reset();
        run_random(15, 1'b0);
        check("instret_full", 32'(instret), 32'hF);
        run_instr(K_R, 0, 0, 1'b0, 0);
        check("instret_wrap", 32'(instret), 32'h0);

        // Randomized traffic, occasionally trapping and recovering by reset.
        run_random(150, 1'b1);

        // Reset asserted while an LW waits in MEM with mem_req high.
        do_reset();
        plan(K_LW, 0, 5, 1'b0, 0);
        for (int i = 0; i < 4; i++) run_step("midmem_cycle");
        begin
            step_t s;
            s = script.pop_front();
            opcode = s.op; mem_ready = s.rdy; zero = s.z;
            #1;
            check("midmem_pre", 32'(obs), 32'(s.exp));
            rst_n = 1'b0;
            #1;
            check("midmem_state", 32'(state), 32'd0);
            check("midmem_req", 32'(mem_req), 32'd0);
            check("midmem_instret", 32'(instret), 32'd0);
            script.delete();
            @(negedge clk);
            rst_n = 1'b1;
            exp_cnt = '0;
        end
        run_random(5, 1'b0);

        // Illegal opcode 1111111: trap for 20 cycles, then reset recovers.
        plan(K_LW, 0, 0, 1'b0, 0);
        script.delete();
        begin
            add(rnd_op(), 1'b1, 1'b0, vec(3'd0, 7'b1001100, 2'b00, 3'b000));
            add(7'b1111111, 1'b0, 1'b0, vec(3'd1, 7'b0000000, 2'b00, 3'b000));
            for (int i = 0; i < 20; i++)
                add(rnd_op(), rnd_bit(), rnd_bit(), vec(3'd5, 7'b0000000, 2'b00, 3'b001));
            $display("instr opcode=7f trap cycles=%0d", script.size());
            while (script.size() > 0) run_step("trap_cycle");
        end
        check("trap_instret", 32'(instret), 32'(exp_cnt));
        do_reset();
        run_instr(K_BEQ, 0, 0, 1'b1, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
